// File: rtl/dvp_cam_tx.sv
// DVP (OV7670-style) camera transmitter: sends RGB565 frames high byte first on cam_vsync/cam_href/cam_dat,
// sourced from a valid/ready pixel stream or from a built-in {line, column} test pattern.
module dvp_cam_tx #(
   parameter int H_ACTIVE = 40,
   parameter int V_ACTIVE = 30,
   parameter int H_BLANK  = 16,
   parameter int V_SYNC   = 8,
   parameter int V_BACK   = 8,
   parameter int V_FRONT  = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        enable,
   input  logic        pattern_en,
   input  logic [15:0] pix_data,
   input  logic        pix_valid,
   output logic        pix_ready,
   output logic        cam_vsync,
   output logic        cam_href,
   output logic [7:0]  cam_dat,
   output logic        frame_done,
   output logic        underrun
);

   localparam int BYTES = 2 * H_ACTIVE;
   localparam int BW    = $clog2(BYTES);
   localparam int LW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int PMAX_A = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
   localparam int PMAX_B = (H_BLANK > V_FRONT) ? H_BLANK : V_FRONT;
   localparam int PMAX   = (PMAX_A > PMAX_B) ? PMAX_A : PMAX_B;
   localparam int PW     = (PMAX > 1) ? $clog2(PMAX) : 1;

   localparam logic [BW-1:0] BYTE_LAST  = BW'(BYTES - 1);
   localparam logic [LW-1:0] LINE_LAST  = LW'(V_ACTIVE - 1);
   localparam logic [PW-1:0] SYNC_LAST  = PW'(V_SYNC - 1);
   localparam logic [PW-1:0] BACK_LAST  = PW'(V_BACK - 1);
   localparam logic [PW-1:0] BLANK_LAST = PW'(H_BLANK - 1);
   localparam logic [PW-1:0] FRONT_LAST = PW'(V_FRONT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_BLANK, S_VFRONT
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            w_phase_end;
   logic            w_start;
   logic [PW-1:0]   r_phase;
   logic [BW-1:0]   r_byte;
   logic [LW-1:0]   r_line;
   logic            r_pat;
   logic [7:0]      r_lo;
   logic [7:0]      w_col;
   logic [7:0]      w_line8;

   logic            r_ready;
   logic            r_vsync;
   logic            r_href;
   logic [7:0]      r_dat;
   logic            r_done;
   logic            r_under;

   assign w_col   = 8'(r_byte >> 1);
   assign w_line8 = 8'(r_line);
   assign w_start = (w_state_nxt == S_VSYNC) && (r_state != S_VSYNC);

   // NOTE: every combinational output gets a default before the case so no latch can be inferred.
   always_comb begin
      w_phase_end = 1'b0;
      w_state_nxt = r_state;
      case (r_state)
         S_VSYNC:  w_phase_end = (r_phase == SYNC_LAST);
         S_VBACK:  w_phase_end = (r_phase == BACK_LAST);
         S_BLANK:  w_phase_end = (r_phase == BLANK_LAST);
         S_VFRONT: w_phase_end = (r_phase == FRONT_LAST);
         default:  w_phase_end = 1'b0;
      endcase
      case (r_state)
         S_IDLE:   if (enable) w_state_nxt = S_VSYNC;
         S_VSYNC:  if (w_phase_end) w_state_nxt = S_VBACK;
         S_VBACK:  if (w_phase_end) w_state_nxt = S_ACTIVE;
         S_ACTIVE: if (r_byte == BYTE_LAST) w_state_nxt = S_BLANK;
         S_BLANK:  if (w_phase_end) w_state_nxt = (r_line == LINE_LAST) ? S_VFRONT : S_ACTIVE;
         S_VFRONT: if (w_phase_end) w_state_nxt = enable ? S_VSYNC : S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_phase <= '0;
         r_byte  <= '0;
         r_line  <= '0;
         r_pat   <= 1'b0;
         r_lo    <= 8'h00;
         r_ready <= 1'b0;
         r_vsync <= 1'b0;
         r_href  <= 1'b0;
         r_dat   <= 8'h00;
         r_done  <= 1'b0;
         r_under <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         if (w_state_nxt != r_state) begin
            r_phase <= '0;
            r_byte  <= '0;
         end else begin
            if (r_state inside {S_VSYNC, S_VBACK, S_BLANK, S_VFRONT}) r_phase <= r_phase + PW'(1);
            if (r_state == S_ACTIVE) r_byte <= r_byte + BW'(1);
         end

         // Line index survives the ACTIVE/BLANK ping-pong and clears once the frame leaves video.
         if (r_state == S_BLANK && w_state_nxt == S_ACTIVE) r_line <= r_line + LW'(1);
         else if (w_state_nxt != S_ACTIVE && w_state_nxt != S_BLANK) r_line <= '0;

         if (w_start) r_pat <= pattern_en;

         // Outputs trail the state by one cycle; pix_ready leads each high byte by one.
         r_vsync <= (r_state == S_VSYNC);
         r_href  <= (r_state == S_ACTIVE);
         r_done  <= (r_state == S_VFRONT) && w_phase_end;
         r_ready <= !r_pat &&
                    (((w_state_nxt == S_ACTIVE) && (r_state != S_ACTIVE)) ||
                     ((r_state == S_ACTIVE) && r_byte[0] && (r_byte != BYTE_LAST)));

         if (r_ready) r_lo <= pix_valid ? pix_data[7:0] : 8'h00;

         if (r_ready && !pix_valid) r_under <= 1'b1;
         else if (r_state == S_VSYNC && r_phase == '0) r_under <= 1'b0;

         if (r_state == S_ACTIVE) begin
            if (r_pat) r_dat <= r_byte[0] ? w_col : w_line8;
            else       r_dat <= r_byte[0] ? r_lo : (pix_valid ? pix_data[15:8] : 8'h00);
         end else begin
            r_dat <= 8'h00;
         end
      end
   end

   assign pix_ready  = r_ready;
   assign cam_vsync  = r_vsync;
   assign cam_href   = r_href;
   assign cam_dat    = r_dat;
   assign frame_done = r_done;
   assign underrun   = r_under;

endmodule
